bcd_disp_mux: RTL and testbench

//  Consumes the 16-bit packed BCD result of the BCD adder stage (0..1099) and drives a
//  4-digit time-multiplexed 7-segment display. Holds the value in a shadow register,

---
 rtl/bcd_disp_mux.sv | 187 ++++++++++++++++++
 tb/tb_bcd_disp_mux.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_disp_mux.sv
// rtl/bcd_disp_mux.sv - 4-digit multiplexed 7-segment driver for packed BCD values
//
// Holds an incoming BCD value in a shadow register and commits it to the
// display register only at a frame boundary (digit 3 -> digit 0 wrap), so a
// single scan frame never shows a mix of two values. Digits are scanned at
// REFRESH_DIV clocks per slot. Leading zeros can be blanked, and any nibble
// above 9 is shown as 'E' and raises err.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous reset, active low
//   bcd_in     in   [15:0] packed BCD, [3:0] = digit 0 (units)
//   dp_in      in   [3:0] decimal point enables, bit k = digit k
//   in_valid   in   bcd_in/dp_in valid
//   in_ready   out  value can be accepted (transfer on in_valid & in_ready)
//   seg        out  [6:0] segments {a,b,c,d,e,f,g}
//   dp         out  decimal point of the active digit
//   an         out  [3:0] digit enables, at most one enabled
//   err        out  committed value holds a non-BCD nibble
//   frame_tick out  one-cycle pulse after each frame boundary

module bcd_disp_mux #(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit BLANK_LZ       = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bcd_in,
    input  logic [3:0]  dp_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        err,
    output logic        frame_tick
);

    localparam int             PW       = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0]  PRESC_TC = PW'(REFRESH_DIV - 1);
    localparam logic [6:0]     SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic           DP_OFF   = SEG_ACTIVE_LOW;
    localparam logic [3:0]     AN_OFF   = AN_ACTIVE_LOW ? 4'hF : 4'h0;

    // Active-high segment pattern; anything above 9 renders as 'E'.
    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'd0:    p = 7'b1111110;
            4'd1:    p = 7'b0110000;
            4'd2:    p = 7'b1101101;
            4'd3:    p = 7'b1111001;
            4'd4:    p = 7'b0110011;
            4'd5:    p = 7'b1011011;
            4'd6:    p = 7'b1011111;
            4'd7:    p = 7'b1110000;
            4'd8:    p = 7'b1111111;
            4'd9:    p = 7'b1111011;
            default: p = 7'b1001111;
        endcase
        return p;
    endfunction

    function automatic logic has_non_bcd(input logic [15:0] v);
        return (v[3:0] > 4'd9) || (v[7:4] > 4'd9) ||
               (v[11:8] > 4'd9) || (v[15:12] > 4'd9);
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic          pending_q, pending_d;
    logic [15:0]   shadow_bcd_q, shadow_bcd_d;
    logic [3:0]    shadow_dp_q, shadow_dp_d;
    logic [15:0]   disp_q, disp_d;
    logic [3:0]    dpreg_q, dpreg_d;
    logic          err_q, err_d;
    logic          frame_tick_q, frame_tick_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    an_q, an_d;

    logic          tc;
    logic          frame_bnd;
    logic          accept;
    logic          commit;
    logic [3:0]    nib;
    logic          blank;
    logic [6:0]    seg_on;
    logic          dp_on;
    logic [3:0]    an_on;

    always_comb begin
        tc           = (presc_q == PRESC_TC);
        presc_d      = tc ? '0 : presc_q + PW'(1);
        idx_d        = tc ? idx_q + 2'd1 : idx_q;
        frame_bnd    = tc && (idx_q == 2'd3);
        frame_tick_d = frame_bnd;

        // Accept requires pending=0 and commit requires pending=1,
        // so the two can never happen in the same cycle.
        accept       = in_valid && !pending_q;
        commit       = frame_bnd && pending_q;

        pending_d    = pending_q;
        shadow_bcd_d = shadow_bcd_q;
        shadow_dp_d  = shadow_dp_q;
        disp_d       = disp_q;
        dpreg_d      = dpreg_q;
        err_d        = err_q;

        if (accept) begin
            shadow_bcd_d = bcd_in;
            shadow_dp_d  = dp_in;
            pending_d    = 1'b1;
        end
        if (commit) begin
            disp_d    = shadow_bcd_q;
            dpreg_d   = shadow_dp_q;
            err_d     = has_non_bcd(shadow_bcd_q);
            pending_d = 1'b0;
        end

        // Output registers are loaded from next-state values so the display
        // shows the new slot (and a freshly committed value) one cycle after TC.
        case (idx_d)
            2'd0:    nib = disp_d[3:0];
            2'd1:    nib = disp_d[7:4];
            2'd2:    nib = disp_d[11:8];
            default: nib = disp_d[15:12];
        endcase

        case (idx_d)
            2'd1:    blank = BLANK_LZ && (disp_d[15:4] == 12'd0);
            2'd2:    blank = BLANK_LZ && (disp_d[15:8] == 8'd0);
            2'd3:    blank = BLANK_LZ && (disp_d[15:12] == 4'd0);
            default: blank = 1'b0;
        endcase

        an_on  = blank ? 4'b0000 : (4'b0001 << idx_d);
        seg_on = blank ? 7'b0000000 : seg_decode(nib);
        dp_on  = !blank && dpreg_d[idx_d];

        an_d   = AN_ACTIVE_LOW  ? ~an_on  : an_on;
        seg_d  = SEG_ACTIVE_LOW ? ~seg_on : seg_on;
        dp_d   = SEG_ACTIVE_LOW ? ~dp_on  : dp_on;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= 2'd0;
            pending_q    <= 1'b0;
            shadow_bcd_q <= 16'd0;
            shadow_dp_q  <= 4'd0;
            disp_q       <= 16'd0;
            dpreg_q      <= 4'd0;
            err_q        <= 1'b0;
            frame_tick_q <= 1'b0;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            an_q         <= AN_OFF;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            shadow_bcd_q <= shadow_bcd_d;
            shadow_dp_q  <= shadow_dp_d;
            disp_q       <= disp_d;
            dpreg_q      <= dpreg_d;
            err_q        <= err_d;
            frame_tick_q <= frame_tick_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
        end
    end

    assign in_ready   = ~pending_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign err        = err_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_bcd_disp_mux.sv
// tb/tb_bcd_disp_mux.sv - directed self-checking bench for bcd_disp_mux

module tb_bcd_disp_mux;

    logic        clk;
    logic        rst_n;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        err;
    logic        frame_tick;

    int passed = 0;
    int total  = 0;

    // Active-low segment patterns
    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S5 = 7'b0100100;
    localparam logic [6:0] S7 = 7'b0001111;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0000100;
    localparam logic [6:0] SE = 7'b0110000;
    localparam logic [6:0] SB = 7'b1111111;

    bcd_disp_mux #(
        .REFRESH_DIV   (4),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW (1'b1),
        .BLANK_LZ      (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bcd_in    (bcd_in),
        .dp_in     (dp_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .err       (err),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else
            passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns in the cycle frame_tick is high (slot 0, first cycle of a frame).
    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!frame_tick && n < 40);
        check({tag, "_tick_seen"}, frame_tick, 1);
    endtask

    task automatic send(input string tag, input logic [15:0] v, input logic [3:0] d);
        bcd_in   = v;
        dp_in    = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check({tag, "_ready_low"}, in_ready, 0);
    endtask

    // Packed expectations ordered {slot3, slot2, slot1, slot0}.
    task automatic check_frame(input string tag, input logic [27:0] seg_e,
                               input logic [15:0] an_e, input logic [3:0] dp_e);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_an%0d", tag, k), an, an_e[k*4 +: 4]);
            check($sformatf("%s_seg%0d", tag, k), seg, seg_e[k*7 +: 7]);
            check($sformatf("%s_dp%0d", tag, k), dp, dp_e[k]);
            if (k < 3) repeat (4) step();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"}, an, 4'hF);
        check({tag, "_seg"}, seg, SB);
        check({tag, "_dp"}, dp, 1);
        check({tag, "_ready"}, in_ready, 1);
        check({tag, "_err"}, err, 0);
        check({tag, "_tick"}, frame_tick, 0);
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        bcd_in   = 16'h0;
        dp_in    = 4'h0;
        in_valid = 1'b0;
        repeat (3) step();
        check_reset_outputs("rst");

        // 1: idle after reset
        rst_n = 1'b1;
        step();
        check("t1_first_an", an, 4'b1110);
        check("t1_first_seg", seg, S0);
        wait_frame("t1a");
        n = 0;
        do begin
            step();
            n++;
            if (n == 1) check("t1_tick_pulse", frame_tick, 0);
        end while (!frame_tick && n < 40);
        check("t1_tick_period", n, 16);
        check("t1_ready", in_ready, 1);
        check("t1_err", err, 0);
        check_frame("t1", {SB, SB, SB, S0}, 16'hFFFE, 4'hF);

        // 2: all four digits plus decimal point
        send("t2", 16'h1098, 4'b0100);
        wait_frame("t2");
        check("t2_ready", in_ready, 1);
        check("t2_err", err, 0);
        check_frame("t2", {S1, S0, S9, S8}, 16'h7BDE, 4'b1011);

        // 3: leading-zero blanking
        send("t3a", 16'h0007, 4'h0);
        wait_frame("t3a");
        check_frame("t3a", {SB, SB, SB, S7}, 16'hFFFE, 4'hF);
        wait_frame("t3b");
        check_frame("t3b", {SB, SB, SB, S7}, 16'hFFFE, 4'hF);
        send("t3c", 16'h0100, 4'h0);
        wait_frame("t3c");
        check_frame("t3c", {SB, S1, S0, S0}, 16'hFBDE, 4'hF);

        // 4: held in_valid, back-to-back values
        bcd_in   = 16'h0042;
        dp_in    = 4'h0;
        in_valid = 1'b1;
        step();
        check("t4_ready_low", in_ready, 0);
        bcd_in = 16'h0055;
        n = 0;
        do begin
            step();
            n++;
        end while (!in_ready && n < 40);
        check("t4_ready_at_commit", frame_tick, 1);
        step();
        check("t4_second_accepted", in_ready, 0);
        check_frame("t4a", {SB, SB, S4, S2}, 16'hFFDE, 4'hF);
        in_valid = 1'b0;
        wait_frame("t4b");
        check_frame("t4b", {SB, SB, S5, S5}, 16'hFFDE, 4'hF);

        // 5: non-BCD nibble
        send("t5a", 16'h00A5, 4'h0);
        wait_frame("t5a");
        check("t5_err_set", err, 1);
        check_frame("t5a", {SB, SB, SE, S5}, 16'hFFDE, 4'hF);
        send("t5b", 16'h0005, 4'h0);
        wait_frame("t5b");
        check("t5_err_clr", err, 0);
        check_frame("t5b", {SB, SB, SB, S5}, 16'hFFFE, 4'hF);

        // 6: reset mid slot 2 with a value pending
        send("t6a", 16'h1234, 4'hF);
        wait_frame("t6a");
        check_frame("t6a", {S1, S2, S3, S4}, 16'h7BDE, 4'h0);
        wait_frame("t6b");
        send("t6b", 16'h5678, 4'h0);
        repeat (8) step();
        check("t6_pre_an", an, 4'b1011);
        check("t6_pre_dp", dp, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        repeat (2) step();
        check_reset_outputs("t6_rst_hold");
        rst_n = 1'b1;
        step();
        check("t6_rel_an", an, 4'b1110);
        check("t6_rel_seg", seg, S0);
        check("t6_rel_ready", in_ready, 1);
        wait_frame("t6c");
        check_frame("t6c", {SB, SB, SB, S0}, 16'hFFFE, 4'hF);
        wait_frame("t6d");
        check_frame("t6d", {SB, SB, SB, S0}, 16'hFFFE, 4'hF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
